// File: rtl/video_pixel_fetch_if.sv
// Bus bundle between the video timing/render side and the pixel fetch block.
// The slave modport is the fetch block; the master modport is its environment.
interface video_pixel_fetch_if;
  logic        next_frame;
  logic        next_line;
  logic        next_pixel;
  logic [7:0]  hscale;
  logic [7:0]  vscale;
  logic [9:0]  hstart;
  logic [9:0]  hstop;
  logic [9:0]  vstart;
  logic [9:0]  vstop;
  logic [7:0]  border_color;
  logic        pal_wr_en;
  logic [7:0]  pal_wr_addr;
  logic [11:0] pal_wr_data;
  logic [9:0]  linebuf_rd_addr;
  logic [7:0]  linebuf_rd_data;
  logic [9:0]  line_idx;
  logic        render_start;
  logic [11:0] palette_rgb_data;

  modport master (
    output next_frame, next_line, next_pixel,
    output hscale, vscale, hstart, hstop, vstart, vstop, border_color,
    output pal_wr_en, pal_wr_addr, pal_wr_data,
    output linebuf_rd_data,
    input  linebuf_rd_addr, line_idx, render_start, palette_rgb_data
  );

  modport slave (
    input  next_frame, next_line, next_pixel,
    input  hscale, vscale, hstart, hstop, vstart, vstop, border_color,
    input  pal_wr_en, pal_wr_addr, pal_wr_data,
    input  linebuf_rd_data,
    output linebuf_rd_addr, line_idx, render_start, palette_rgb_data
  );
endinterface

// File: rtl/video_pixel_fetch.sv
// Scaled pixel fetch: walks a line buffer with a 10.7 fixed-point horizontal
// accumulator, picks window or border palette index, and looks the colour up
// in a 256x12 palette RAM. Vertical accumulator drives line render requests.
module video_pixel_fetch (
  input  logic               clk,
  input  logic               rst_n,
  video_pixel_fetch_if.slave bus
);

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_run;

  logic [16:0] r_hacc;
  logic [9:0]  r_x_cnt;
  logic [16:0] r_vacc;
  logic [9:0]  r_y_cnt;
  logic [9:0]  r_line_idx;
  logic        r_render_start;

  logic        w_inwin;
  logic [9:0]  r_addr_p0;
  logic        r_inwin_p0;
  logic [7:0]  w_pal_idx_p1;
  logic [11:0] r_pal_q_p1;
  logic [11:0] r_rgb_p2;

  logic [11:0] r_pal_mem [0:255];

  // Saturating 10-bit increment for the horizontal pixel counter.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    sat_inc10 = (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_FRAME;
    else        r_state <= w_state_nxt;
  end

  // Next state: the first frame pulse starts the block, only reset stops it.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = (r_state == RUN);
    if (bus.next_frame) w_state_nxt = RUN;
  end

  // Horizontal source position; line start wins over a pixel advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hacc  <= '0;
      r_x_cnt <= '0;
    end else if (bus.next_line) begin
      r_hacc  <= '0;
      r_x_cnt <= '0;
    end else if (bus.next_pixel) begin
      r_hacc  <= r_hacc + {9'd0, bus.hscale};
      r_x_cnt <= sat_inc10(r_x_cnt);
    end
  end

  // Vertical source position and render request; the line index reported
  // is the source line the accumulator pointed at before this step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vacc         <= '0;
      r_y_cnt        <= '0;
      r_line_idx     <= '0;
      r_render_start <= 1'b0;
    end else begin
      r_render_start <= bus.next_frame | (w_run & bus.next_line);
      if (bus.next_frame) begin
        r_vacc     <= '0;
        r_y_cnt    <= '0;
        r_line_idx <= '0;
      end else if (bus.next_line) begin
        r_line_idx <= r_vacc[16:7];
        r_vacc     <= r_vacc + {9'd0, bus.vscale};
        r_y_cnt    <= r_y_cnt + 10'd1;
      end
    end
  end

  // An empty range (start >= stop) never matches, giving an all-border frame.
  assign w_inwin = (r_x_cnt >= bus.hstart) && (r_x_cnt < bus.hstop) &&
                   (r_y_cnt >= bus.vstart) && (r_y_cnt < bus.vstop);

  // ---- stage 0: issue line-buffer address and window flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_p0  <= '0;
      r_inwin_p0 <= 1'b0;
    end else if (bus.next_pixel) begin
      r_addr_p0  <= r_hacc[16:7];
      r_inwin_p0 <= w_inwin;
    end
  end

  // ---- stage 1: choose palette index, synchronous palette read
  assign w_pal_idx_p1 = r_inwin_p0 ? bus.linebuf_rd_data : bus.border_color;

  // Palette contents survive reset; a same-cycle write is seen by the next read.
  always_ff @(posedge clk) begin
    if (bus.pal_wr_en) r_pal_mem[bus.pal_wr_addr] <= bus.pal_wr_data;
  end

  // Palette read register, stepping with the pixel strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_pal_q_p1 <= '0;
    else if (bus.next_pixel)  r_pal_q_p1 <= r_pal_mem[w_pal_idx_p1];
  end

  // ---- stage 2: colour output, forced black until the first frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_rgb_p2 <= '0;
    else if (!w_run)          r_rgb_p2 <= '0;
    else if (bus.next_pixel)  r_rgb_p2 <= r_pal_q_p1;
  end

  assign bus.linebuf_rd_addr  = r_addr_p0;
  assign bus.line_idx         = r_line_idx;
  assign bus.render_start     = r_render_start;
  assign bus.palette_rgb_data = r_rgb_p2;

endmodule

// File: tb/tb_video_pixel_fetch.sv
// Bench for video_pixel_fetch: vertical control table plus a scoreboarded
// pixel pipeline with a behavioural line buffer (data = address[7:0]).
module tb_video_pixel_fetch;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [11:0] pal_model [0:255];
  int          y_model;
  int          vst_m;
  int          vsp_m;

  typedef struct {
    logic       nf;
    logic       nl;
    logic       exp_rs;
    logic [9:0] exp_idx;
  } vrow_t;

  vrow_t vtab [13];

  video_pixel_fetch_if bus ();

  video_pixel_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.linebuf_rd_data = bus.linebuf_rd_addr[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_v(input int vs, input int ve);
    vst_m = vs;
    vsp_m = ve;
    bus.vstart = 10'(vs);
    bus.vstop  = 10'(ve);
  endtask

  task automatic pal_write(input int a, input logic [11:0] d);
    bus.pal_wr_en   = 1'b1;
    bus.pal_wr_addr = 8'(a);
    bus.pal_wr_data = d;
    tick();
    bus.pal_wr_en   = 1'b0;
    pal_model[a]    = d;
  endtask

  task automatic frame();
    bus.next_frame = 1'b1;
    tick();
    bus.next_frame = 1'b0;
    y_model = 0;
    chk("frame_render_start", 32'(bus.render_start), 32'd1);
    chk("frame_line_idx", 32'(bus.line_idx), 32'd0);
  endtask

  // One output line: next_line pulse, then n cycles of stimulus. Colours are
  // expected two pixel steps after their address step; wr_step >= 0 writes
  // palette[3] in that pixel step.
  task automatic run_line(input int hs, input int hst, input int hsp, input int bc,
                          input int n, input bit toggle, input int wr_step,
                          input logic [11:0] wr_data, input string name);
    logic [11:0] q [$];
    logic [11:0] col;
    logic [11:0] last_col;
    bit          have_col;
    bit          np;
    bit          inwin;
    int          k;
    int          acc;
    int          exp_addr;
    int          last_addr;
    int          idx;
    bus.hscale       = 8'(hs);
    bus.hstart       = 10'(hst);
    bus.hstop        = 10'(hsp);
    bus.border_color = 8'(bc);
    bus.next_line    = 1'b1;
    tick();
    bus.next_line    = 1'b0;
    y_model++;
    k         = 0;
    have_col  = 1'b0;
    last_addr = 0;
    last_col  = '0;
    for (int i = 0; i < n; i++) begin
      np = toggle ? ((i % 2) == 0) : 1'b1;
      bus.next_pixel = np;
      if (np && k == wr_step) begin
        bus.pal_wr_en   = 1'b1;
        bus.pal_wr_addr = 8'd3;
        bus.pal_wr_data = wr_data;
        pal_model[3]    = wr_data;
      end
      if (np) begin
        acc      = (k * hs) % 131072;
        exp_addr = acc / 128;
        inwin    = (k >= hst) && (k < hsp) && (y_model >= vst_m) && (y_model < vsp_m);
        idx      = inwin ? (exp_addr % 256) : bc;
        col      = pal_model[idx];
        q.push_back(col);
        last_addr = exp_addr;
        k++;
      end
      tick();
      bus.pal_wr_en  = 1'b0;
      bus.next_pixel = 1'b0;
      if (np) begin
        chk({name, "_addr"}, 32'(bus.linebuf_rd_addr), 32'(exp_addr));
        if (q.size() == 3) begin
          last_col = q.pop_front();
          have_col = 1'b1;
          chk({name, "_rgb"}, 32'(bus.palette_rgb_data), 32'(last_col));
        end
      end else if (k > 0) begin
        chk({name, "_addr_hold"}, 32'(bus.linebuf_rd_addr), 32'(last_addr));
        if (have_col) chk({name, "_rgb_hold"}, 32'(bus.palette_rgb_data), 32'(last_col));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    y_model  = 0;

    vtab[0]  = '{1'b1, 1'b0, 1'b1, 10'd0};
    vtab[1]  = '{1'b0, 1'b0, 1'b0, 10'd0};
    vtab[2]  = '{1'b0, 1'b1, 1'b1, 10'd0};
    vtab[3]  = '{1'b0, 1'b0, 1'b0, 10'd0};
    vtab[4]  = '{1'b0, 1'b1, 1'b1, 10'd0};
    vtab[5]  = '{1'b0, 1'b1, 1'b1, 10'd1};
    vtab[6]  = '{1'b0, 1'b1, 1'b1, 10'd1};
    vtab[7]  = '{1'b0, 1'b0, 1'b0, 10'd1};
    vtab[8]  = '{1'b1, 1'b1, 1'b1, 10'd0};
    vtab[9]  = '{1'b0, 1'b0, 1'b0, 10'd0};
    vtab[10] = '{1'b0, 1'b1, 1'b1, 10'd0};
    vtab[11] = '{1'b0, 1'b1, 1'b1, 10'd0};
    vtab[12] = '{1'b0, 1'b1, 1'b1, 10'd1};

    rst_n            = 1'b0;
    bus.next_frame   = 1'b0;
    bus.next_line    = 1'b0;
    bus.next_pixel   = 1'b0;
    bus.hscale       = 8'd128;
    bus.vscale       = 8'd64;
    bus.hstart       = 10'd0;
    bus.hstop        = 10'd640;
    bus.border_color = 8'd0;
    bus.pal_wr_en    = 1'b0;
    bus.pal_wr_addr  = 8'd0;
    bus.pal_wr_data  = 12'd0;
    set_v(0, 480);

    tick(); tick(); tick();
    chk("rst_rgb", 32'(bus.palette_rgb_data), 32'd0);
    chk("rst_render_start", 32'(bus.render_start), 32'd0);
    chk("rst_line_idx", 32'(bus.line_idx), 32'd0);
    chk("rst_rd_addr", 32'(bus.linebuf_rd_addr), 32'd0);
    rst_n = 1'b1;

    // Palette load while waiting for the first frame, with pixels advancing.
    bus.next_pixel = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pal_write(i, 12'(i));
      if ((i % 32) == 31) chk("wait_rgb_zero", 32'(bus.palette_rgb_data), 32'd0);
      chk("wait_render_quiet", 32'(bus.render_start), 32'd0);
    end
    bus.next_pixel = 1'b0;

    // Vertical control table, vscale = 64.
    for (int r = 0; r < 13; r++) begin
      bus.next_frame = vtab[r].nf;
      bus.next_line  = vtab[r].nl;
      tick();
      chk($sformatf("vtab%0d_render_start", r), 32'(bus.render_start), 32'(vtab[r].exp_rs));
      chk($sformatf("vtab%0d_line_idx", r), 32'(bus.line_idx), 32'(vtab[r].exp_idx));
    end
    bus.next_frame = 1'b0;
    bus.next_line  = 1'b0;
    tick();

    frame();
    run_line(128, 0, 640, 0, 20, 1'b0, -1, 12'h000, "h128");
    run_line(64, 0, 640, 0, 16, 1'b0, -1, 12'h000, "h64");
    run_line(128, 0, 640, 0, 24, 1'b1, -1, 12'h000, "toggle");
    pal_write(5, 12'hF00);
    run_line(128, 10, 20, 5, 30, 1'b0, -1, 12'h000, "window");
    run_line(128, 20, 10, 5, 8, 1'b0, -1, 12'h000, "empty_win");
    set_v(100, 480);
    run_line(128, 0, 640, 5, 8, 1'b0, -1, 12'h000, "vwin");
    set_v(0, 480);
    run_line(0, 0, 640, 0, 8, 1'b0, -1, 12'h000, "h0");
    run_line(0, 0, 0, 3, 12, 1'b0, 5, 12'hABC, "pal_rw");

    // Reset in the middle of a line.
    bus.hscale     = 8'd128;
    bus.next_line  = 1'b1;
    tick();
    bus.next_line  = 1'b0;
    bus.next_pixel = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rgb", 32'(bus.palette_rgb_data), 32'd0);
    chk("midrst_rd_addr", 32'(bus.linebuf_rd_addr), 32'd0);
    chk("midrst_line_idx", 32'(bus.line_idx), 32'd0);
    chk("midrst_render_start", 32'(bus.render_start), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("postrst_rgb_zero", 32'(bus.palette_rgb_data), 32'd0);
    end
    bus.next_pixel = 1'b0;
    tick();
    frame();
    run_line(128, 0, 640, 0, 12, 1'b0, -1, 12'h000, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
